// File: rtl/decode_unit_pkg.sv
// rtl/decode_unit_pkg.sv - shared opcode codes and RV32I major-opcode constants
// Purpose: internal opcode enumeration, its width, and RV32I major opcodes used by
//          decode_unit and rv32i_field_decode.
// Ports:   none (package).
package decode_unit_pkg;

  localparam int DEC_OP_W = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [DEC_OP_W-1:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_NOP
  } op_e;

endpackage

// File: rtl/decode_unit_field_decode.sv
// rtl/decode_unit_field_decode.sv - combinational RV32I field decoder
// Purpose: maps a raw RV32I word to internal opcode, register indices, immediate
//          and illegal flag. Unused register fields are forced to 0.
// Ports:   instr   - raw 32-bit instruction
//          op      - internal opcode (OP_NOP when illegal)
//          rd/rs1/rs2 - register indices
//          imm     - sign-extended immediate (shift amounts zero-extended)
//          illegal - unknown opcode or funct3
module rv32i_field_decode
  import decode_unit_pkg::*;
#(
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic [31:0]          instr,
  output op_e                  op,
  output logic [REG_IDX_W-1:0] rd,
  output logic [REG_IDX_W-1:0] rs1,
  output logic [REG_IDX_W-1:0] rs2,
  output logic [DATA_W-1:0]    imm,
  output logic                 illegal
);

  logic [2:0] f3;
  logic       alt;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign f3    = instr[14:12];
  assign alt   = instr[30];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt = {27'b0, instr[24:20]};

  logic use_rd, use_rs1, use_rs2;
  logic signed [31:0] imm32;

  always_comb begin
    op      = OP_NOP;
    illegal = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    unique case (instr[6:0])
      OPC_LUI:   begin op = OP_LUI;   use_rd = 1'b1; imm32 = imm_u; end
      OPC_AUIPC: begin op = OP_AUIPC; use_rd = 1'b1; imm32 = imm_u; end
      OPC_JAL:   begin op = OP_JAL;   use_rd = 1'b1; imm32 = imm_j; end
      OPC_JALR: begin
        op = OP_JALR; use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i;
        if (f3 != 3'd0) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_b;
        case (f3)
          3'd0: op = OP_BEQ;
          3'd1: op = OP_BNE;
          3'd4: op = OP_BLT;
          3'd5: op = OP_BGE;
          3'd6: op = OP_BLTU;
          3'd7: op = OP_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i;
        case (f3)
          3'd0: op = OP_LB;
          3'd1: op = OP_LH;
          3'd2: op = OP_LW;
          3'd4: op = OP_LBU;
          3'd5: op = OP_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_s;
        case (f3)
          3'd0: op = OP_SB;
          3'd1: op = OP_SH;
          3'd2: op = OP_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i;
        case (f3)
          3'd0: op = OP_ADDI;
          3'd1: begin op = OP_SLLI; imm32 = shamt; end
          3'd2: op = OP_SLTI;
          3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI;
          3'd5: begin op = alt ? OP_SRAI : OP_SRLI; imm32 = shamt; end
          3'd6: op = OP_ORI;
          default: op = OP_ANDI;
        endcase
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'd0: op = alt ? OP_SUB : OP_ADD;
          3'd1: op = OP_SLL;
          3'd2: op = OP_SLT;
          3'd3: op = OP_SLTU;
          3'd4: op = OP_XOR;
          3'd5: op = alt ? OP_SRA : OP_SRL;
          3'd6: op = OP_OR;
          default: op = OP_AND;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // An illegal word carries no meaningful fields: emit a clean NOP record.
    if (illegal) begin
      op      = OP_NOP;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      imm32   = '0;
    end
  end

  assign rd  = use_rd  ? REG_IDX_W'(instr[11:7])  : '0;
  assign rs1 = use_rs1 ? REG_IDX_W'(instr[19:15]) : '0;
  assign rs2 = use_rs2 ? REG_IDX_W'(instr[24:20]) : '0;
  // Size cast of a signed value sign-extends (or truncates) to DATA_W.
  assign imm = DATA_W'(imm32);

endmodule

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - RV32I decode stage with DEPTH-entry output buffer
// Purpose: accepts instructions, decodes them combinationally at accept and
//          queues decoded records in a circular buffer for the consumer.
// Ports:   clk, rst (async active-high), flush (clears buffer at next edge)
//          in_valid/in_ready/in_pc/in_instr - instruction input handshake
//          out_valid/out_ready/out_* - head record of the buffer
//          count - number of buffered entries
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32,
  parameter int OP_W      = DEC_OP_W,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REG_IDX_W-1:0]       out_rd,
  output logic [REG_IDX_W-1:0]       out_rs1,
  output logic [REG_IDX_W-1:0]       out_rs2,
  output logic [DATA_W-1:0]          out_imm,
  output logic [OP_W-1:0]            out_op,
  output logic [DATA_W-1:0]          out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  op_e                  dec_op;
  logic [REG_IDX_W-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [DATA_W-1:0]    dec_imm;
  logic                 dec_illegal;

  rv32i_field_decode #(
    .REG_IDX_W (REG_IDX_W),
    .DATA_W    (DATA_W)
  ) u_field (
    .instr   (in_instr),
    .op      (dec_op),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Held low through reset so in_ready only rises on the first edge after release.
  logic             ready_q, ready_d;

  logic [REG_IDX_W-1:0] rd_mem_q  [DEPTH];
  logic [REG_IDX_W-1:0] rs1_mem_q [DEPTH];
  logic [REG_IDX_W-1:0] rs2_mem_q [DEPTH];
  logic [DATA_W-1:0]    imm_mem_q [DEPTH];
  logic [OP_W-1:0]      op_mem_q  [DEPTH];
  logic [DATA_W-1:0]    pc_mem_q  [DEPTH];
  logic                 ill_mem_q [DEPTH];

  logic push, pop;

  assign in_ready  = ready_q && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ready_d  = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      rd_mem_q[wr_ptr_q]  <= dec_rd;
      rs1_mem_q[wr_ptr_q] <= dec_rs1;
      rs2_mem_q[wr_ptr_q] <= dec_rs2;
      imm_mem_q[wr_ptr_q] <= dec_imm;
      op_mem_q[wr_ptr_q]  <= OP_W'(dec_op);
      pc_mem_q[wr_ptr_q]  <= in_pc;
      ill_mem_q[wr_ptr_q] <= dec_illegal;
    end
  end

  // Storage is not reset, so outputs are forced to 0 while rst is high.
  assign out_rd      = rst ? '0   : rd_mem_q[rd_ptr_q];
  assign out_rs1     = rst ? '0   : rs1_mem_q[rd_ptr_q];
  assign out_rs2     = rst ? '0   : rs2_mem_q[rd_ptr_q];
  assign out_imm     = rst ? '0   : imm_mem_q[rd_ptr_q];
  assign out_op      = rst ? '0   : op_mem_q[rd_ptr_q];
  assign out_pc      = rst ? '0   : pc_mem_q[rd_ptr_q];
  assign out_illegal = rst ? 1'b0 : ill_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - self-checking bench for decode_unit
module tb_decode_unit;
  import decode_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm, out_pc;
  logic [5:0]  out_op;
  logic [1:0]  count;

  decode_unit #(.REG_IDX_W(5), .DATA_W(32), .OP_W(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_op(out_op), .out_pc(out_pc),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill;
    bit          fields;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  exp_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   m_count = 0;
  bit   m_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input exp_t e);
    nxt      = e;
    in_instr = e.instr;
    in_pc    = e.pc;
    in_valid = 1'b1;
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [5:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic ill, input bit fields);
    exp_t e;
    e.instr = instr; e.pc = pc; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.ill = ill; e.fields = fields;
    return e;
  endfunction

  // One clock: check handshake/count against the model, compare the head with the
  // scoreboard, update the model, then advance to 1 time unit after the edge.
  task automatic cycle();
    bit   exp_rdy, acc, pp;
    exp_t h;
    exp_rdy = m_ready && (m_count < DEPTH);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_count != 0);
    chk("count", count, m_count);
    if (m_count != 0) begin
      h = sb[0];
      chk("op", out_op, h.op);
      chk("illegal", out_illegal, h.ill);
      if (h.fields) begin
        chk("rd", out_rd, h.rd);
        chk("rs1", out_rs1, h.rs1);
        chk("rs2", out_rs2, h.rs2);
        chk("imm", out_imm, h.imm);
        chk("pc", out_pc, h.pc);
      end
    end
    acc = in_valid && exp_rdy && !flush;
    pp  = (m_count != 0) && out_ready && !flush;
    if (pp) void'(sb.pop_front());
    if (acc) sb.push_back(nxt);
    m_count = m_count + int'(acc) - int'(pp);
    if (flush) begin
      sb.delete();
      m_count = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = mk(32'hFFF10093, 32'h100, OP_ADDI, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1);
    vecs[1] = mk(32'hFE208CE3, 32'h104, OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b0, 1'b1);
    vecs[2] = mk(32'h40335293, 32'h108, OP_SRAI, 5'd5, 5'd6, 5'd0, 32'h00000003, 1'b0, 1'b1);
    vecs[3] = mk(32'h123450B7, 32'h10C, OP_LUI,  5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1);
    vecs[4] = mk(32'h0020A423, 32'h110, OP_SW,   5'd0, 5'd1, 5'd2, 32'h00000008, 1'b0, 1'b1);
    vecs[5] = mk(32'h402081B3, 32'h114, OP_SUB,  5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0, 1'b1);
    vecs[6] = mk(32'hFFDFF0EF, 32'h118, OP_JAL,  5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b1);

    // Reset state, asserted between edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 2'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_data", {out_rd, out_rs1, out_rs2, out_illegal}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_op", out_op, 6'd0);
    chk("rst_pc", out_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    m_ready = 1'b1;

    // Single push with latency check, then a back-to-back stream with out_ready=1.
    out_ready = 1'b1;
    drive(vecs[0]); cycle();
    in_valid = 1'b0; cycle();
    for (int i = 1; i < 7; i++) begin
      drive(vecs[i]); cycle();
    end
    in_valid = 1'b0; cycle(); cycle();

    // Fill to DEPTH with consumer stalled; third push is held off until space frees.
    out_ready = 1'b0;
    drive(vecs[3]); cycle();
    drive(vecs[4]); cycle();
    drive(vecs[5]); cycle();
    chk("full_count", count, 2'd2);
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    cycle();

    // Flush a full buffer with a push pending.
    drive(vecs[0]); cycle();
    drive(vecs[1]); cycle();
    drive(vecs[2]); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 2'd0);
    chk("flush_valid", out_valid, 1'b0);
    cycle();
    drive(mk(32'h00000000, 32'h200, OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0)); cycle();
    in_valid = 1'b0; out_ready = 1'b1; cycle();
    cycle();

    // Reset mid-operation with two entries buffered.
    out_ready = 1'b0;
    drive(vecs[5]); cycle();
    drive(vecs[6]); cycle();
    in_valid = 1'b0;
    chk("pre_rst_count", count, 2'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_count", count, 2'd0);
    chk("mid_rst_ready", in_ready, 1'b0);
    sb.delete(); m_count = 0; m_ready = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    drive(vecs[2]); cycle();
    in_valid = 1'b0; out_ready = 1'b1; cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
